// File: rtl/auto_play_seq.sv
// ---------------------------------------------------------------------------
// auto_play_seq
//
// Auto-play sequencer for the electronic-piano top level. The user selects a
// song and a tempo level, starts/pauses/stops playback and may loop a song.
// The block clocks the song library, rewinds it to the song start, watches
// for the end-of-song note and builds the 8-character tube display text.
//
// Ports:
//   clk             system clock
//   enable          synchronous active-low reset
//   up / down       next / previous song (level buttons, edge-detected)
//   left / right    tempo level +1 / -1 (saturating)
//   Begin           play/pause toggle
//   loop_mode       1 = restart the song at its end, 0 = stop at its end
//   lib_in_note     current note from the song library
//   lib_clk         library advance clock
//   lib_RorW        library read/write select, always read (0)
//   lib_back_to     0 = library held at song start, 1 = library running
//   lib_song_select song index presented to the library
//   tub_text        eight 5-bit character codes, leftmost character in MSBs
// ---------------------------------------------------------------------------
module auto_play_seq #(
  parameter int              SONG_W      = 3,
  parameter int              BPM_W       = 3,
  parameter int              BPM_DEFAULT = 3,
  parameter int              DIV_BASE    = 10,
  parameter int              DIV_STEP    = 15,
  parameter int              NOTE_W      = 5,
  parameter logic [NOTE_W-1:0] END_CODE  = {NOTE_W{1'b1}},
  parameter int              CNT_W       = 16
) (
  input  logic              clk,
  input  logic              enable,
  input  logic              up,
  input  logic              down,
  input  logic              left,
  input  logic              right,
  input  logic              Begin,
  input  logic              loop_mode,
  input  logic [NOTE_W-1:0] lib_in_note,
  output logic              lib_clk,
  output logic              lib_RorW,
  output logic              lib_back_to,
  output logic [SONG_W-1:0] lib_song_select,
  output logic [39:0]       tub_text
);

  typedef enum logic [1:0] {
    IDLE,
    PLAY,
    PAUSE,
    REWIND
  } state_t;

  localparam logic [4:0] CH_BLANK = 5'd21;

  state_t            state;
  logic [SONG_W-1:0] song;
  logic [BPM_W-1:0]  bpm;
  logic [CNT_W-1:0]  counter;
  logic              started;
  logic              rew_cnt;

  // Button order in the vectors: {up, down, left, right, Begin}.
  logic [4:0] btn_q;
  logic [4:0] btn_prev;
  logic [4:0] rise;

  logic song_inc, song_dec, song_chg;
  logic bpm_inc, bpm_dec;
  logic begin_rise;
  logic end_hit;
  logic [CNT_W-1:0] limit;

  assign lib_RorW = 1'b0;

  assign rise       = btn_q & ~btn_prev;
  // Opposing buttons pressed together cancel each other out.
  assign song_inc   = rise[4] & ~rise[3];
  assign song_dec   = rise[3] & ~rise[4];
  assign song_chg   = song_inc | song_dec;
  assign bpm_inc    = rise[2] & ~rise[1];
  assign bpm_dec    = rise[1] & ~rise[2];
  assign begin_rise = rise[0];
  assign end_hit    = started && (lib_in_note == END_CODE);

  assign limit = CNT_W'(DIV_BASE) + CNT_W'(DIV_STEP) * CNT_W'(bpm);

  function automatic logic [39:0] text_of(input state_t st,
                                          input logic [SONG_W-1:0] s,
                                          input logic [BPM_W-1:0] b);
    logic [4:0] sc;
    logic [4:0] bc;
    sc = 5'(s);
    bc = 5'(b);
    case (st)
      IDLE:    text_of = {5'd15, 5'd23, 5'd15, 5'd24, CH_BLANK, bc, CH_BLANK, sc};
      PAUSE:   text_of = {5'd18, 5'd19, 5'd10, 5'd22, CH_BLANK, bc, CH_BLANK, sc};
      default: text_of = {5'd18, 5'd19, 5'd10, 5'd22, 5'd1,     bc, CH_BLANK, sc};
    endcase
  endfunction

  // NOTE: all state is updated with non-blocking assignments so every branch
  // below sees the values from before this edge, independent of ordering.
  always_ff @(posedge clk) begin
    if (!enable) begin
      state           <= IDLE;
      song            <= '0;
      bpm             <= BPM_W'(BPM_DEFAULT);
      counter         <= '0;
      started         <= 1'b0;
      rew_cnt         <= 1'b0;
      lib_clk         <= 1'b0;
      lib_back_to     <= 1'b0;
      lib_song_select <= '0;
      btn_q           <= '0;
      btn_prev        <= '0;
      tub_text        <= text_of(IDLE, '0, BPM_W'(BPM_DEFAULT));
    end else begin
      btn_q    <= {up, down, left, right, Begin};
      btn_prev <= btn_q;
      tub_text <= text_of(state, song, bpm);

      if (song_inc) song <= song + 1'b1;
      if (song_dec) song <= song - 1'b1;

      if (bpm_inc && bpm != '1) bpm <= bpm + 1'b1;
      if (bpm_dec && bpm != '0) bpm <= bpm - 1'b1;

      case (state)
        IDLE: begin
          lib_back_to <= 1'b0;
          lib_clk     <= 1'b0;
          counter     <= '0;
          if (begin_rise && !song_chg) begin
            state           <= PLAY;
            lib_song_select <= song;
            started         <= 1'b0;
            lib_back_to     <= 1'b1;
          end
        end

        PLAY: begin
          if (song_chg) begin
            state       <= IDLE;
            lib_back_to <= 1'b0;
            lib_clk     <= 1'b0;
            counter     <= '0;
          end else if (begin_rise) begin
            state <= PAUSE;
          end else if (end_hit) begin
            state       <= loop_mode ? REWIND : IDLE;
            rew_cnt     <= 1'b0;
            lib_back_to <= 1'b0;
            lib_clk     <= 1'b0;
            counter     <= '0;
          end else begin
            lib_back_to <= 1'b1;
            // NOTE: >= rather than == so a tempo decrease that leaves the
            // counter above the new limit toggles at once instead of wrapping.
            if (counter >= limit) begin
              counter <= '0;
              lib_clk <= ~lib_clk;
              if (!lib_clk) started <= 1'b1;
            end else begin
              counter <= counter + 1'b1;
            end
          end
        end

        PAUSE: begin
          if (song_chg) begin
            state       <= IDLE;
            lib_back_to <= 1'b0;
            lib_clk     <= 1'b0;
            counter     <= '0;
          end else if (begin_rise) begin
            state <= PLAY;
          end
        end

        REWIND: begin
          lib_clk <= 1'b0;
          counter <= '0;
          if (song_chg) begin
            state       <= IDLE;
            lib_back_to <= 1'b0;
          end else if (rew_cnt) begin
            state       <= PLAY;
            started     <= 1'b0;
            lib_back_to <= 1'b1;
          end else begin
            rew_cnt     <= 1'b1;
            lib_back_to <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
